dynamic_curve_apply: RTL and testbench
======================================

// Module: dynamic_curve_apply
// PURPOSE
//  Downstream consumer of the per-frame brightness parameters p_q (curve gain, Q8.8) and p2_q
//  (dark-lift strength). Sits directly after the parameter stage on the same delayed video stream.
//  Latches both parameters at each vsync rising edge and builds a 256-entry tone curve into a shadow
//  bank during blanking. Swaps banks at vsync fall and remaps every R/G/B sample through the active curve.
// PARAMETERS
//  DARK_TH  64   dark-lift region upper bound; lift applies for x < DARK_TH
//  QVAL     255  output saturation ceiling
//  GSHIFT   16   right shift applied to the gain product
//  DSHIFT   8    right shift applied to the dark-lift product
// PORTS
//  clk       in   1   pixel clock
//  rst_n     in   1   asynchronous active-low reset
//  i_v       in   1   vsync, active high
//  i_h       in   1   hsync
//  i_de      in   1   data enable
//  i_rgb     in   24  {R,G,B} 8b each
//  p_q       in   16  curve gain Q8.8; value sampled only at the i_v rising edge
//  p2_q      in   8   dark-lift strength; value sampled only at the i_v rising edge
//  o_v/o_h/o_de out 1 sync/de delayed by exactly 2 clk
//  o_rgb     out  24  remapped pixel, 2 clk after i_rgb
//  lut_busy  out  1   high while the curve build is in progress
//  o_overrun out  1   1-clk pulse when a swap is skipped because the build has not finished
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, active bank=0, curve_valid=0, latched params=0.
//  Until the first swap, curve_valid=0 and o_rgb = i_rgb delayed 2 clk (bypass).
//  Edge detection uses a registered i_v. rise = i_v & ~v_d; fall = ~i_v & v_d.
//  FSM states and transitions:
//   - IDLE -> CALC on rise. Latch p_q and p2_q. Set addr=0.
//   - CALC: issue one entry per clk, addr 0..255. The arithmetic is a 2-stage pipeline, so writes lag issue by 2.
//     When the last write (entry 255) lands, go to READY. lut_busy=1 throughout CALC, 258 clk total.
//   - READY -> IDLE on fall. Swap banks (active <= ~active) and set curve_valid=1.
//  Entry arithmetic, x = addr:
//   - boost = (pq * x * (255-x)) >> GSHIFT, using a 24b unsigned product. Max 587*16256 fits.
//   - dark = (x < DARK_TH) ? (p2q * (DARK_TH-x)) >> DSHIFT : 0.
//   - y = min(QVAL, x + boost + dark), with a 10b intermediate sum.
//  Writes go only to the shadow bank (~active). The active bank is never written.
//  Apply path:
//   - Stage 1 registers three reads from the active bank, addressed by R, G and B.
//   - Stage 2 registers o_rgb, which is muxed with the bypass when curve_valid=0.
//   - Syncs are shifted 2 deep to stay aligned.
//  Boundary conditions:
//   - fall while in CALC: no swap, 1-clk o_overrun pulse. The build continues to READY and the swap waits
//     for the next fall.
//   - rise while in CALC or READY: ignored, latched params unchanged. A rise in READY does not rebuild.
//   - rise and fall in the same clk cannot occur (edge detector).
//   - i_de is ignored by the FSM. Pixels present during CALC still use the active bank.
//   - reset mid-build: FSM=IDLE, shadow contents don't-care, curve_valid=0, so output returns to bypass.
// TESTING
//  1 Before any vsync, i_rgb=0x102030 with i_de=1 -> o_rgb=0x102030 exactly 2 clk later, o_de aligned.
//  2 p_q=0, p2_q=0, full vsync cycle -> identity curve; ramp 0..255 on all channels -> output = input.
//  3 p_q=256, p2_q=0 -> x=128 maps to 191, x=0 maps to 0, x=255 maps to 255.
//  4 p_q=0, p2_q=255 -> x=0 maps to 63, x=63 maps to 63, x=64 maps to 64.
//  5 p_q=587 -> x=200 saturates to 255.
//  6 fall 100 clk after rise -> o_overrun pulses for 1 clk, old curve kept; swap occurs at the next fall;
//    lut_busy high for 258 clk.

Source files
------------

// File: rtl/dynamic_curve_apply.sv
// Per-frame tone curve: builds a 256-entry LUT into a shadow bank during vblank, then remaps R/G/B.
// Latency 2 clk pixel-in to pixel-out; no backpressure, the video stream is free-running.
`timescale 1ns/1ps
module dynamic_curve_apply #(
    parameter int DARK_TH = 64,
    parameter int QVAL    = 255,
    parameter int GSHIFT  = 16,
    parameter int DSHIFT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_v,
    input  logic        i_h,
    input  logic        i_de,
    input  logic [23:0] i_rgb,
    input  logic [15:0] p_q,
    input  logic [7:0]  p2_q,
    output logic        o_v,
    output logic        o_h,
    output logic        o_de,
    output logic [23:0] o_rgb,
    output logic        lut_busy,
    output logic        o_overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [8:0] DARK_TH_W = 9'(DARK_TH);
    localparam logic [7:0] QVAL_B    = 8'(QVAL);
    localparam logic [8:0] CALC_LAST = 9'd257;

    // ---------------- control state ----------------
    logic        v_d_q;
    logic        rise, fall;
    logic [1:0]  state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] gain_q, gain_d;
    logic [7:0]  lift_q, lift_d;
    logic        active_q, active_d;
    logic        curve_valid_q, curve_valid_d;
    logic        overrun_q, overrun_d;

    assign rise = i_v & ~v_d_q;
    assign fall = ~i_v & v_d_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gain_d        = gain_q;
        lift_d        = lift_q;
        active_d      = active_q;
        curve_valid_d = curve_valid_q;
        overrun_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    gain_d  = p_q;
                    lift_d  = p2_q;
                end
            end
            S_CALC: begin
                // cnt runs 0..257: 256 issues plus two cycles for the pipeline to drain
                cnt_d = cnt_q + 9'd1;
                if (fall) overrun_d = 1'b1;
                if (cnt_q == CALC_LAST) state_d = S_READY;
            end
            S_READY: begin
                if (fall) begin
                    state_d       = S_IDLE;
                    active_d      = ~active_q;
                    curve_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_d_q         <= 1'b0;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            gain_q        <= '0;
            lift_q        <= '0;
            active_q      <= 1'b0;
            curve_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            v_d_q         <= i_v;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gain_q        <= gain_d;
            lift_q        <= lift_d;
            active_q      <= active_d;
            curve_valid_q <= curve_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign lut_busy  = (state_q == S_CALC);
    assign o_overrun = overrun_q;

    // ---------------- curve build pipeline ----------------
    logic        issue;
    logic [7:0]  x;
    logic [15:0] mx_w;
    logic [15:0] dark_w;

    assign issue = (state_q == S_CALC) && !cnt_q[8];
    assign x     = cnt_q[7:0];
    assign mx_w  = 16'(x) * (16'd255 - 16'(x));

    always_comb begin
        dark_w = '0;
        if ({1'b0, x} < DARK_TH_W)
            dark_w = (16'(lift_q) * 16'(DARK_TH_W - {1'b0, x})) >> DSHIFT;
    end

    logic        s1_vld_q;
    logic [7:0]  s1_x_q;
    logic [15:0] s1_mx_q;
    logic [15:0] s1_dark_q;
    logic        s2_vld_q;
    logic [7:0]  s2_addr_q;
    logic [7:0]  s2_y_q;

    logic [23:0] prod_w;
    logic [23:0] boost_w;
    logic [9:0]  sum_w;
    logic [7:0]  y_w;

    // 24b product is enough: the largest in-range gain (587) times max x*(255-x) (16256) fits
    assign prod_w  = 24'(gain_q * s1_mx_q);
    assign boost_w = prod_w >> GSHIFT;
    assign sum_w   = 10'(s1_x_q) + 10'(boost_w) + 10'(s1_dark_q);
    assign y_w     = (sum_w > {2'b00, QVAL_B}) ? QVAL_B : sum_w[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_mx_q   <= '0;
            s1_dark_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_y_q    <= '0;
        end else begin
            s1_vld_q  <= issue;
            s1_x_q    <= x;
            s1_mx_q   <= mx_w;
            s1_dark_q <= dark_w;
            s2_vld_q  <= s1_vld_q;
            s2_addr_q <= s1_x_q;
            s2_y_q    <= y_w;
        end
    end

    // Two banks in one array, bank select is the MSB; only the shadow bank is written
    logic [7:0] lut_mem [0:511];

    always_ff @(posedge clk) begin
        if (s2_vld_q) lut_mem[{~active_q, s2_addr_q}] <= s2_y_q;
    end

    // ---------------- apply path ----------------
    logic        v1_q, h1_q, de1_q;
    logic [23:0] rgb1_q;
    logic        cv1_q;
    logic [7:0]  r1_q, g1_q, b1_q;
    logic        v2_q, h2_q, de2_q;
    logic [23:0] rgb2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            h1_q   <= 1'b0;
            de1_q  <= 1'b0;
            rgb1_q <= '0;
            cv1_q  <= 1'b0;
            r1_q   <= '0;
            g1_q   <= '0;
            b1_q   <= '0;
            v2_q   <= 1'b0;
            h2_q   <= 1'b0;
            de2_q  <= 1'b0;
            rgb2_q <= '0;
        end else begin
            v1_q   <= i_v;
            h1_q   <= i_h;
            de1_q  <= i_de;
            rgb1_q <= i_rgb;
            // bypass select travels with the lookup so a swap never splits a pixel
            cv1_q  <= curve_valid_q;
            r1_q   <= lut_mem[{active_q, i_rgb[23:16]}];
            g1_q   <= lut_mem[{active_q, i_rgb[15:8]}];
            b1_q   <= lut_mem[{active_q, i_rgb[7:0]}];
            v2_q   <= v1_q;
            h2_q   <= h1_q;
            de2_q  <= de1_q;
            rgb2_q <= cv1_q ? {r1_q, g1_q, b1_q} : rgb1_q;
        end
    end

    assign o_v   = v2_q;
    assign o_h   = h2_q;
    assign o_de  = de2_q;
    assign o_rgb = rgb2_q;

endmodule

// File: tb/tb_dynamic_curve_apply.sv
// Scoreboard bench for dynamic_curve_apply: directed frames with hand-computed curve points.
`timescale 1ns/1ps
module tb_dynamic_curve_apply;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_v, i_h, i_de;
    logic [23:0] i_rgb;
    logic [15:0] p_q;
    logic [7:0]  p2_q;
    logic        o_v, o_h, o_de;
    logic [23:0] o_rgb;
    logic        lut_busy, o_overrun;

    always #5 clk = ~clk;

    dynamic_curve_apply dut (
        .clk(clk), .rst_n(rst_n), .i_v(i_v), .i_h(i_h), .i_de(i_de), .i_rgb(i_rgb),
        .p_q(p_q), .p2_q(p2_q), .o_v(o_v), .o_h(o_h), .o_de(o_de), .o_rgb(o_rgb),
        .lut_busy(lut_busy), .o_overrun(o_overrun)
    );

    typedef struct {
        logic [23:0] rgb;
        int          stamp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    int   ovr_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [2:0] hist1, hist2;
    int         hv = 0;
    exp_t       e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hv = 0;
        end else begin
            if (hv >= 2) check("sync_align", {29'd0, o_v, o_h, o_de}, {29'd0, hist2});
            hist2 = hist1;
            hist1 = {i_v, i_h, i_de};
            if (hv < 2) hv++;
            if (lut_busy)  busy_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_de) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %0h with empty scoreboard (cycle %0d)", o_rgb, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pixel", {8'd0, o_rgb}, {8'd0, e.rgb});
                    check("latency", cyc, e.stamp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [23:0] rgb, input logic [23:0] exp_rgb);
        i_rgb = rgb;
        i_de  = 1'b1;
        i_h   = rgb[0];
        sb.push_back('{rgb: exp_rgb, stamp: cyc + 3});
        tick(1);
        i_de  = 1'b0;
        i_h   = 1'b0;
        i_rgb = 24'h0;
    endtask

    // Full vsync: params shown at the rise, then scrambled so only the latched copy matters
    task automatic frame(input logic [15:0] pq, input logic [7:0] p2q, input string name);
        busy_cnt = 0;
        ovr_cnt  = 0;
        p_q  = pq;
        p2_q = p2q;
        i_v  = 1'b1;
        tick(2);
        p_q  = 16'hDEAD;
        p2_q = 8'hBE;
        tick(268);
        i_v  = 1'b0;
        tick(4);
        check({name, "_busy_cycles"}, busy_cnt, 258);
        check({name, "_no_overrun"}, ovr_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_v = 1'b0; i_h = 1'b0; i_de = 1'b0; i_rgb = 24'h0;
        p_q = 16'h0; p2_q = 8'h0;
        tick(3);
        check("reset_o_rgb", {8'd0, o_rgb}, 32'd0);
        check("reset_o_de", {31'd0, o_de}, 32'd0);
        check("reset_lut_busy", {31'd0, lut_busy}, 32'd0);
        check("reset_o_overrun", {31'd0, o_overrun}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        // bypass before any curve exists
        send_px(24'h102030, 24'h102030);
        tick(2);
        send_px(24'hA5FF00, 24'hA5FF00);
        tick(4);

        // identity curve, ramp on all channels
        frame(16'd0, 8'd0, "ident");
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v8;
            v8 = 8'(x);
            send_px({v8, ~v8, v8 ^ 8'h5A}, {v8, ~v8, v8 ^ 8'h5A});
        end
        tick(4);

        // gain 1.0: 128->191, 64->111, ends fixed
        frame(16'd256, 8'd0, "gain256");
        send_px({8'd128, 8'd0, 8'd255}, {8'd191, 8'd0, 8'd255});
        send_px({8'd64, 8'd64, 8'd64}, {8'd111, 8'd111, 8'd111});
        tick(4);

        // full dark lift: 0->63, 63->63, 64->64, 32->63, 10->63
        frame(16'd0, 8'd255, "lift255");
        send_px({8'd0, 8'd63, 8'd64}, {8'd63, 8'd63, 8'd64});
        send_px({8'd32, 8'd10, 8'd200}, {8'd63, 8'd63, 8'd200});
        tick(4);

        // gain and lift together: 16->54, 0->32, 255->255
        frame(16'd256, 8'd128, "mixed");
        send_px({8'd16, 8'd0, 8'd255}, {8'd54, 8'd32, 8'd255});
        tick(4);

        // strong gain saturates: 200->255, 128->255, 20->62
        frame(16'd587, 8'd0, "gain587");
        send_px({8'd200, 8'd128, 8'd20}, {8'd255, 8'd255, 8'd62});
        tick(4);

        // fall during build: overrun, old curve stays, pixels mid-build use the active bank
        busy_cnt = 0;
        ovr_cnt  = 0;
        p_q  = 16'd0;
        p2_q = 8'd0;
        i_v  = 1'b1;
        tick(100);
        i_v  = 1'b0;
        tick(130);
        send_px({8'd200, 8'd128, 8'd20}, {8'd255, 8'd255, 8'd62});
        tick(60);
        check("overrun_pulse_cycles", ovr_cnt, 1);
        check("overrun_busy_cycles", busy_cnt, 258);
        send_px({8'd200, 8'd128, 8'd20}, {8'd255, 8'd255, 8'd62});
        tick(4);
        // rise in READY must not rebuild or relatch; the next fall swaps in identity
        p_q  = 16'd256;
        i_v  = 1'b1;
        tick(20);
        i_v  = 1'b0;
        tick(4);
        check("ready_rise_no_rebuild", busy_cnt, 258);
        send_px({8'd200, 8'd128, 8'd20}, {8'd200, 8'd128, 8'd20});
        tick(4);

        // reset in the middle of a build returns to bypass
        frame(16'd256, 8'd0, "pre_reset");
        send_px({8'd128, 8'd128, 8'd128}, {8'd191, 8'd191, 8'd191});
        tick(4);
        p_q = 16'd587;
        i_v = 1'b1;
        tick(50);
        check("midbuild_busy", {31'd0, lut_busy}, 32'd1);
        rst_n = 1'b0;
        tick(2);
        check("midbuild_reset_busy", {31'd0, lut_busy}, 32'd0);
        i_v   = 1'b0;
        rst_n = 1'b1;
        tick(3);
        send_px({8'd128, 8'd128, 8'd128}, {8'd128, 8'd128, 8'd128});
        tick(6);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
